// File: rtl/cu_pkg.sv
//------------------------------------------------------------------------------
// Module      : cu_pkg
// Description : Shared definitions for the control unit: 5-bit instruction
//               opcodes, 4-bit ALU operation codes, FSM state encoding and
//               the decoded instruction class.
// Config      : CU_MULDIV_EN (consumed by cu_op_decode / control_unit)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  // Instruction opcodes, IR[31:27]
  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_MUL  = 5'b01111;
  localparam logic [4:0] c_OP_DIV  = 5'b10000;
  localparam logic [4:0] c_OP_JR   = 5'b10011;
  localparam logic [4:0] c_OP_JAL  = 5'b10100;
  localparam logic [4:0] c_OP_IN   = 5'b10101;
  localparam logic [4:0] c_OP_OUT  = 5'b10110;
  localparam logic [4:0] c_OP_NOP  = 5'b11010;
  localparam logic [4:0] c_OP_HALT = 5'b11011;

  // ALU operation codes driven on opCode
  localparam logic [3:0] c_ALU_NONE = 4'b0000;
  localparam logic [3:0] c_ALU_ADD  = 4'b0001;
  localparam logic [3:0] c_ALU_SUB  = 4'b0010;
  localparam logic [3:0] c_ALU_MUL  = 4'b0011;
  localparam logic [3:0] c_ALU_DIV  = 4'b0100;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_HALT  = 4'd8
  } state_t;

  // Decoded instruction class
  typedef enum logic [3:0] {
    CL_ALU3   = 4'd0,
    CL_ALUI   = 4'd1,
    CL_MULDIV = 4'd2,
    CL_JR     = 4'd3,
    CL_JAL    = 4'd4,
    CL_IN     = 4'd5,
    CL_OUT    = 4'd6,
    CL_NOP    = 4'd7,
    CL_HALT   = 4'd8
  } iclass_t;

endpackage : cu_pkg

`default_nettype wire

// File: rtl/control_unit_if.sv
//------------------------------------------------------------------------------
// Module      : control_unit_if
// Description : Control bundle between the sequencer and the datapath.
//               master : control_unit (drives strobes, reads IR / Stop)
//               slave  : datapath side (reads strobes, drives IR / Stop)
// Signals     : IR[31:0], Stop          - datapath -> sequencer
//               Run, bus drivers, register loads, incPC, read,
//               Gra/Grb/Grc, opCode[3:0] - sequencer -> datapath
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface control_unit_if;

  logic [31:0] IR;
  logic        Stop;
  logic        Run;

  // Bus drivers
  logic        PCout, Zlowout, Zhighout, MDRout, Rout, Cout, In_Portout;
  // Register loads
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin;
  logic        Out_Portin, Lnkin;
  // Misc controls
  logic        incPC, read;
  logic        Gra, Grb, Grc;
  logic [3:0]  opCode;

  modport master (
    input  IR, Stop,
    output Run,
    output PCout, Zlowout, Zhighout, MDRout, Rout, Cout, In_Portout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
    output Out_Portin, Lnkin,
    output incPC, read, Gra, Grb, Grc, opCode
  );

  modport slave (
    output IR, Stop,
    input  Run,
    input  PCout, Zlowout, Zhighout, MDRout, Rout, Cout, In_Portout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
    input  Out_Portin, Lnkin,
    input  incPC, read, Gra, Grb, Grc, opCode
  );

endinterface : control_unit_if

`default_nettype wire

// File: rtl/cu_op_decode.sv
//------------------------------------------------------------------------------
// Module      : cu_op_decode
// Description : Combinational decode of the latched opcode into an
//               instruction class and the ALU operation for T4.
// Ports       : i_opcode[4:0] - latched IR[31:27]
//               o_class       - instruction class (iclass_t)
//               o_alu_op[3:0] - ALU operation code
// Config      : CU_MULDIV_EN - when undefined, mul/div decode as nop
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cu_op_decode
  import cu_pkg::*;
(
  input  wire logic [4:0] i_opcode,
  output iclass_t         o_class,
  output logic [3:0]      o_alu_op
);

  always_comb begin
    // Anything not listed (including nop itself) behaves as nop
    o_class  = CL_NOP;
    o_alu_op = c_ALU_NONE;
    case (i_opcode)
      c_OP_ADD:  begin o_class = CL_ALU3; o_alu_op = c_ALU_ADD; end
      c_OP_SUB:  begin o_class = CL_ALU3; o_alu_op = c_ALU_SUB; end
      c_OP_ADDI: begin o_class = CL_ALUI; o_alu_op = c_ALU_ADD; end
`ifdef CU_MULDIV_EN
      c_OP_MUL:  begin o_class = CL_MULDIV; o_alu_op = c_ALU_MUL; end
      c_OP_DIV:  begin o_class = CL_MULDIV; o_alu_op = c_ALU_DIV; end
`endif
      c_OP_JR:   o_class = CL_JR;
      c_OP_JAL:  o_class = CL_JAL;
      c_OP_IN:   o_class = CL_IN;
      c_OP_OUT:  o_class = CL_OUT;
      c_OP_HALT: o_class = CL_HALT;
      default:   o_class = CL_NOP;
    endcase
  end

endmodule : cu_op_decode

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// Module      : control_unit
// Description : Hardwired fetch/decode/execute sequencer for the RISC
//               datapath. One state per clock; Moore outputs decoded from
//               the state register and the opcode latched at T2->T3.
// Ports       : clk  - system clock, rising edge
//               clr  - asynchronous active-high reset
//               bus  - control_unit_if.master (IR/Stop in, strobes out)
// Config      : CU_MULDIV_EN - enables mul/div (T5 LOin, T6 HIin); when
//               undefined mul/div decode as nop and HIin/LOin stay 0
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_unit
  import cu_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            clr,
  control_unit_if.master       bus
);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_opcode;
  iclass_t     w_class;
  logic [3:0]  w_alu_op;
  state_t      w_t0_or_halt;
  logic        w_unused_ir;

  // Only the opcode field is used by the sequencer
  assign w_unused_ir = ^bus.IR[26:0];

  cu_op_decode u_decode (
    .i_opcode (r_opcode),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  // Every transition into T0 is an instruction boundary where Stop is honoured
  assign w_t0_or_halt = bus.Stop ? ST_HALT : ST_T0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_RESET;
      r_opcode <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_T2)
        r_opcode <= bus.IR[31:27];
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: w_next = w_t0_or_halt;
      ST_T0:    w_next = ST_T1;
      ST_T1:    w_next = ST_T2;
      ST_T2:    w_next = ST_T3;
      ST_T3: begin
        case (w_class)
          CL_ALU3, CL_ALUI, CL_MULDIV, CL_JAL: w_next = ST_T4;
          CL_HALT:                             w_next = ST_HALT;
          default:                             w_next = w_t0_or_halt;
        endcase
      end
      ST_T4: begin
        if (w_class == CL_JAL) w_next = w_t0_or_halt;
        else                   w_next = ST_T5;
      end
      ST_T5: begin
        if (w_class == CL_MULDIV) w_next = ST_T6;
        else                      w_next = w_t0_or_halt;
      end
      ST_T6:    w_next = w_t0_or_halt;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_RESET;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.Run        = 1'b0;
    bus.PCout      = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.MDRout     = 1'b0;
    bus.Rout       = 1'b0;
    bus.Cout       = 1'b0;
    bus.In_Portout = 1'b0;
    bus.PCin       = 1'b0;
    bus.MARin      = 1'b0;
    bus.MDRin      = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Zin        = 1'b0;
    bus.Rin        = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.Out_Portin = 1'b0;
    bus.Lnkin      = 1'b0;
    bus.incPC      = 1'b0;
    bus.read       = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.opCode     = c_ALU_NONE;

    bus.Run = (r_state != ST_RESET) && (r_state != ST_HALT);

    case (r_state)
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.incPC = 1'b1; bus.Zin = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        case (w_class)
          CL_ALU3, CL_ALUI, CL_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          CL_JR:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          CL_JAL: begin bus.PCout = 1'b1; bus.Lnkin = 1'b1; end
          CL_IN:  begin bus.Gra = 1'b1; bus.Rin = 1'b1; bus.In_Portout = 1'b1; end
          CL_OUT: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Out_Portin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CL_ALU3, CL_MULDIV: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opCode = w_alu_op;
          end
          CL_ALUI: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opCode = w_alu_op;
          end
          CL_JAL: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        if (w_class == CL_MULDIV) begin
`ifdef CU_MULDIV_EN
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
`endif
        end else begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T6: begin
`ifdef CU_MULDIV_EN
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule : control_unit

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit. Each step
//               advances one clock and compares all strobes, Run and opCode
//               against hand-derived values.
// Config      : CU_MULDIV_EN - selects the expected mul behaviour
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;

  control_unit_if u_if ();

  control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector, MSB first
  localparam logic [22:0] c_PCOUT   = 23'h1 << 22;
  localparam logic [22:0] c_ZLOW    = 23'h1 << 21;
  localparam logic [22:0] c_ZHIGH   = 23'h1 << 20;
  localparam logic [22:0] c_MDROUT  = 23'h1 << 19;
  localparam logic [22:0] c_ROUT    = 23'h1 << 18;
  localparam logic [22:0] c_COUT    = 23'h1 << 17;
  localparam logic [22:0] c_INPOUT  = 23'h1 << 16;
  localparam logic [22:0] c_PCIN    = 23'h1 << 15;
  localparam logic [22:0] c_MARIN   = 23'h1 << 14;
  localparam logic [22:0] c_MDRIN   = 23'h1 << 13;
  localparam logic [22:0] c_IRIN    = 23'h1 << 12;
  localparam logic [22:0] c_YIN     = 23'h1 << 11;
  localparam logic [22:0] c_ZIN     = 23'h1 << 10;
  localparam logic [22:0] c_RIN     = 23'h1 << 9;
  localparam logic [22:0] c_HIIN    = 23'h1 << 8;
  localparam logic [22:0] c_LOIN    = 23'h1 << 7;
  localparam logic [22:0] c_OUTPIN  = 23'h1 << 6;
  localparam logic [22:0] c_LNKIN   = 23'h1 << 5;
  localparam logic [22:0] c_INCPC   = 23'h1 << 4;
  localparam logic [22:0] c_READ    = 23'h1 << 3;
  localparam logic [22:0] c_GRA     = 23'h1 << 2;
  localparam logic [22:0] c_GRB     = 23'h1 << 1;
  localparam logic [22:0] c_GRC     = 23'h1 << 0;

  localparam logic [22:0] c_NONE = 23'h0;
  localparam logic [22:0] c_S_T0 = c_PCOUT | c_MARIN | c_INCPC | c_ZIN;
  localparam logic [22:0] c_S_T1 = c_ZLOW | c_PCIN | c_READ | c_MDRIN;
  localparam logic [22:0] c_S_T2 = c_MDROUT | c_IRIN;
  localparam logic [22:0] c_S_A3 = c_GRB | c_ROUT | c_YIN;
  localparam logic [22:0] c_S_A4 = c_GRC | c_ROUT | c_ZIN;
  localparam logic [22:0] c_S_A5 = c_ZLOW | c_GRA | c_RIN;

  logic [22:0] w_strobes;
  assign w_strobes = {u_if.PCout, u_if.Zlowout, u_if.Zhighout, u_if.MDRout,
                      u_if.Rout, u_if.Cout, u_if.In_Portout, u_if.PCin,
                      u_if.MARin, u_if.MDRin, u_if.IRin, u_if.Yin, u_if.Zin,
                      u_if.Rin, u_if.HIin, u_if.LOin, u_if.Out_Portin,
                      u_if.Lnkin, u_if.incPC, u_if.read, u_if.Gra, u_if.Grb,
                      u_if.Grc};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [22:0] es,
                       input logic er, input logic [3:0] eo);
    n_tests++;
    assert (w_strobes === es) else begin
      n_fail++;
      $error("FAIL %s strobes got=%h exp=%h", tag, w_strobes, es);
    end
    n_tests++;
    assert (u_if.Run === er) else begin
      n_fail++;
      $error("FAIL %s Run got=%b exp=%b", tag, u_if.Run, er);
    end
    n_tests++;
    assert (u_if.opCode === eo) else begin
      n_fail++;
      $error("FAIL %s opCode got=%b exp=%b", tag, u_if.opCode, eo);
    end
  endtask

  // Called with the DUT in T0 and IR already set; leaves it in T3
  task automatic fetch(input string tag);
    step(); check({tag, "_T1"}, c_S_T1, 1'b1, 4'b0000);
    step(); check({tag, "_T2"}, c_S_T2, 1'b1, 4'b0000);
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr       = 1'b1;
    u_if.IR   = 32'h0;
    u_if.Stop = 1'b0;

    // Reset held for two cycles
    #1;
    check("rst_async", c_NONE, 1'b0, 4'b0000);
    step(); step();
    check("rst_held", c_NONE, 1'b0, 4'b0000);
    clr = 1'b0;
    step();
    check("rst_T0", c_S_T0, 1'b1, 4'b0000);

    // jal R1: 5 cycles
    u_if.IR = 32'hA0800000;
    fetch("jal");
    check("jal_T3", c_PCOUT | c_LNKIN, 1'b1, 4'b0000);
    step(); check("jal_T4", c_GRA | c_ROUT | c_PCIN, 1'b1, 4'b0000);
    step(); check("jal_T0", c_S_T0, 1'b1, 4'b0000);

    // out R1
    u_if.IR = 32'hB0800000;
    fetch("out");
    check("out_T3", c_GRA | c_ROUT | c_OUTPIN, 1'b1, 4'b0000);
    step(); check("out_T0", c_S_T0, 1'b1, 4'b0000);

    // in R1
    u_if.IR = 32'hA8800000;
    fetch("in");
    check("in_T3", c_GRA | c_RIN | c_INPOUT, 1'b1, 4'b0000);
    step(); check("in_T0", c_S_T0, 1'b1, 4'b0000);

    // jr
    u_if.IR = 32'h98800000;
    fetch("jr");
    check("jr_T3", c_GRA | c_ROUT | c_PCIN, 1'b1, 4'b0000);
    step(); check("jr_T0", c_S_T0, 1'b1, 4'b0000);

    // add R1,R2,R3; IR switched to halt during T4 must not matter
    u_if.IR = 32'h18918000;
    fetch("add");
    check("add_T3", c_S_A3, 1'b1, 4'b0000);
    step();
    u_if.IR = 32'hD8000000;
    check("add_T4", c_S_A4, 1'b1, 4'b0001);
    step(); check("add_T5", c_S_A5, 1'b1, 4'b0000);
    step(); check("add_T0", c_S_T0, 1'b1, 4'b0000);

    // sub
    u_if.IR = 32'h20000000;
    fetch("sub");
    check("sub_T3", c_S_A3, 1'b1, 4'b0000);
    step(); check("sub_T4", c_S_A4, 1'b1, 4'b0010);
    step(); check("sub_T5", c_S_A5, 1'b1, 4'b0000);
    step(); check("sub_T0", c_S_T0, 1'b1, 4'b0000);

    // addi uses Cout in T4
    u_if.IR = 32'h60000000;
    fetch("addi");
    check("addi_T3", c_S_A3, 1'b1, 4'b0000);
    step(); check("addi_T4", c_COUT | c_ZIN, 1'b1, 4'b0001);
    step(); check("addi_T5", c_S_A5, 1'b1, 4'b0000);
    step(); check("addi_T0", c_S_T0, 1'b1, 4'b0000);

    // Undefined opcode 00000 behaves as nop
    u_if.IR = 32'h00000000;
    fetch("undef");
    check("undef_T3", c_NONE, 1'b1, 4'b0000);
    step(); check("undef_T0", c_S_T0, 1'b1, 4'b0000);

    // nop
    u_if.IR = 32'hD0000000;
    fetch("nop");
    check("nop_T3", c_NONE, 1'b1, 4'b0000);
    step(); check("nop_T0", c_S_T0, 1'b1, 4'b0000);

    // mul
    u_if.IR = 32'h78918000;
    fetch("mul");
`ifdef CU_MULDIV_EN
    check("mul_T3", c_S_A3, 1'b1, 4'b0000);
    step(); check("mul_T4", c_S_A4, 1'b1, 4'b0011);
    step(); check("mul_T5", c_ZLOW | c_LOIN, 1'b1, 4'b0000);
    step(); check("mul_T6", c_ZHIGH | c_HIIN, 1'b1, 4'b0000);
    step(); check("mul_T0", c_S_T0, 1'b1, 4'b0000);
`else
    check("mul_T3", c_NONE, 1'b1, 4'b0000);
    step(); check("mul_T0", c_S_T0, 1'b1, 4'b0000);
`endif

    // Stop pulsed in T4 of add: T5 completes, then sticky HALT
    u_if.IR = 32'h18918000;
    fetch("stop");
    step();
    u_if.Stop = 1'b1;
    check("stop_T4", c_S_A4, 1'b1, 4'b0001);
    step(); check("stop_T5", c_S_A5, 1'b1, 4'b0000);
    step();
    u_if.Stop = 1'b0;
    check("stop_halt", c_NONE, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(); check("halt_hold", c_NONE, 1'b0, 4'b0000);
    end

    // Leave HALT via clr, then clr in T4 of the next add
    clr = 1'b1;
    #1;
    check("halt_clr", c_NONE, 1'b0, 4'b0000);
    step();
    clr = 1'b0;
    step(); check("rerun_T0", c_S_T0, 1'b1, 4'b0000);
    fetch("clr");
    step();
    check("clr_T4", c_S_A4, 1'b1, 4'b0001);
    #2;
    clr = 1'b1;
    #1;
    check("clr_mid", c_NONE, 1'b0, 4'b0000);
    step();
    check("clr_hold", c_NONE, 1'b0, 4'b0000);
    clr = 1'b0;
    step(); check("clr_T0", c_S_T0, 1'b1, 4'b0000);

    // halt opcode with Stop also high: single HALT entry
    u_if.IR = 32'hD8000000;
    fetch("halt");
    u_if.Stop = 1'b1;
    check("halt_T3", c_NONE, 1'b1, 4'b0000);
    step(); check("halt_enter", c_NONE, 1'b0, 4'b0000);
    u_if.Stop = 1'b0;
    step(); check("halt_stay", c_NONE, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_control_unit

`default_nettype wire
